// File: rtl/clb_pkg.sv
// Camera Link Base shared definitions: lane geometry, XCLK pattern, word layout.
// Used by both the receiver and the transmit model so the bit mapping stays in one place.
package clb_pkg;

  localparam int CLB_LANES = 4;
  localparam int CLB_SER   = 7;
  localparam int CLB_WORD_W = CLB_LANES * CLB_SER;

  localparam logic [6:0] CLB_CLK_PAT = 7'b1100011;

  localparam int CLB_LVAL_IDX  = 24;
  localparam int CLB_FVAL_IDX  = 25;
  localparam int CLB_DVAL_IDX  = 26;
  localparam int CLB_SPARE_IDX = 27;

  typedef struct packed {
    logic       spare;
    logic       dval;
    logic       fval;
    logic       lval;
    logic [7:0] c;
    logic [7:0] b;
    logic [7:0] a;
  } clb_word_t;

  typedef enum logic [1:0] {
    CLB_HUNT   = 2'd0,
    CLB_CHECK  = 2'd1,
    CLB_LOCKED = 2'd2
  } clb_rx_state_t;

  // Lane n occupies sh[n*7 +: 7] with the oldest bit at the MSB; word bit n*7+k is serial bit k.
  function automatic clb_word_t clb_unpack(input logic [CLB_WORD_W-1:0] sh);
    logic [CLB_WORD_W-1:0] w;
    w = {CLB_WORD_W{1'b0}};
    for (int n = 0; n < CLB_LANES; n++) begin
      for (int k = 0; k < CLB_SER; k++) begin
        w[n*CLB_SER + k] = sh[n*CLB_SER + CLB_SER - 1 - k];
      end
    end
    return clb_word_t'(w);
  endfunction

endpackage

// File: rtl/clb_rx_align.sv
// Camera Link Base alignment: lane shift registers plus HUNT/CHECK/LOCKED tracking of XCLK.
// word_vld and lock_drop are combinational strobes valid in the cycle the 7th bit is present.
module clb_rx_align
  import clb_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CLB_LANES-1:0]  x_d,
  input  logic                  x_clk,
  output logic                  word_vld,
  output clb_word_t             word,
  output logic                  locked,
  output logic                  lock_err,
  output logic                  lock_drop
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

  logic [CLB_SER-1:0]    clk_sh_r;
  logic [CLB_WORD_W-1:0] lane_sh_r;
  clb_rx_state_t         state_r;
  logic [2:0]            phase_r;
  logic [GOOD_W-1:0]     good_r;
  logic [BAD_W-1:0]      bad_r;

  logic match_s;
  logic tick_s;

  // Match detection, word decode and the one-cycle strobes handed to the top.
  always_comb begin
    match_s   = (clk_sh_r == CLB_CLK_PAT);
    tick_s    = (phase_r == 3'd6);
    word      = clb_unpack(lane_sh_r);
    word_vld  = (state_r == CLB_LOCKED) && tick_s && match_s;
    lock_drop = (state_r == CLB_LOCKED) && tick_s && !match_s &&
                (bad_r == BAD_W'(UNLOCK_CNT - 1));
  end

  // Serial capture: newest bit enters at the LSB of every lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sh_r  <= '0;
      lane_sh_r <= '0;
    end else begin
      clk_sh_r <= {clk_sh_r[CLB_SER-2:0], x_clk};
      for (int n = 0; n < CLB_LANES; n++) begin
        lane_sh_r[n*CLB_SER +: CLB_SER] <= {lane_sh_r[n*CLB_SER +: CLB_SER-1], x_d[n]};
      end
    end
  end

  // Alignment FSM with registered locked / lock_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= CLB_HUNT;
      phase_r  <= 3'd0;
      good_r   <= '0;
      bad_r    <= '0;
      locked   <= 1'b0;
      lock_err <= 1'b0;
    end else begin
      lock_err <= 1'b0;
      case (state_r)
        CLB_HUNT: begin
          if (match_s) begin
            state_r <= CLB_CHECK;
            phase_r <= 3'd0;
            good_r  <= GOOD_W'(1);
          end
        end
        CLB_CHECK: begin
          phase_r <= tick_s ? 3'd0 : phase_r + 3'd1;
          if (tick_s) begin
            if (!match_s) begin
              state_r <= CLB_HUNT;
            end else if (good_r + GOOD_W'(1) == GOOD_W'(LOCK_CNT)) begin
              state_r <= CLB_LOCKED;
              locked  <= 1'b1;
              bad_r   <= '0;
            end else begin
              good_r <= good_r + GOOD_W'(1);
            end
          end
        end
        CLB_LOCKED: begin
          phase_r <= tick_s ? 3'd0 : phase_r + 3'd1;
          if (tick_s) begin
            if (match_s) begin
              bad_r <= '0;
            end else if (lock_drop) begin
              state_r  <= CLB_HUNT;
              locked   <= 1'b0;
              lock_err <= 1'b1;
              bad_r    <= '0;
            end else begin
              bad_r <= bad_r + BAD_W'(1);
            end
          end
        end
        default: begin
          state_r <= CLB_HUNT;
          locked  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/clb_rx.sv
// Camera Link Base receiver top: registered pixel outputs and line/frame statistics.
// Statistics advance only on decoded words and are cleared whenever lock is lost.
module clb_rx
  import clb_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       x_d,
  input  logic             x_clk,
  output logic             pix_vld,
  output logic [23:0]      pix_data,
  output logic             lval,
  output logic             fval,
  output logic             dval,
  output logic             spare,
  output logic             locked,
  output logic             lock_err,
  output logic [CNT_W-1:0] line_len,
  output logic             line_stat,
  output logic [CNT_W-1:0] frame_lines,
  output logic             frame_stat
);

  logic       word_vld_s;
  clb_word_t  word_s;
  logic       lock_drop_s;

  logic [CNT_W-1:0] line_cnt_r;
  logic [CNT_W-1:0] frame_cnt_r;
  logic [CNT_W-1:0] lines_next_s;
  logic             line_fall_s;
  logic             fval_fall_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    else    return v + CNT_W'(1);
  endfunction

  clb_rx_align #(
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT)
  ) u_align (
    .clk       (clk),
    .rst       (rst),
    .x_d       (x_d),
    .x_clk     (x_clk),
    .word_vld  (word_vld_s),
    .word      (word_s),
    .locked    (locked),
    .lock_err  (lock_err),
    .lock_drop (lock_drop_s)
  );

  // Edge detection against the previous decoded word; a line ending inside a frame counts first.
  always_comb begin
    line_fall_s = lval & ~word_s.lval;
    fval_fall_s = fval & ~word_s.fval;
    if (line_fall_s && fval) begin
      lines_next_s = sat_inc(frame_cnt_r);
    end else begin
      lines_next_s = frame_cnt_r;
    end
  end

  // Output word registers and statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_vld     <= 1'b0;
      pix_data    <= 24'd0;
      lval        <= 1'b0;
      fval        <= 1'b0;
      dval        <= 1'b0;
      spare       <= 1'b0;
      line_len    <= '0;
      line_stat   <= 1'b0;
      frame_lines <= '0;
      frame_stat  <= 1'b0;
      line_cnt_r  <= '0;
      frame_cnt_r <= '0;
    end else begin
      pix_vld    <= word_vld_s;
      line_stat  <= 1'b0;
      frame_stat <= 1'b0;
      if (lock_drop_s) begin
        lval        <= 1'b0;
        fval        <= 1'b0;
        dval        <= 1'b0;
        line_cnt_r  <= '0;
        frame_cnt_r <= '0;
      end else if (word_vld_s) begin
        pix_data <= {word_s.c, word_s.b, word_s.a};
        lval     <= word_s.lval;
        fval     <= word_s.fval;
        dval     <= word_s.dval;
        spare    <= word_s.spare;
        if (line_fall_s) begin
          line_len   <= line_cnt_r;
          line_stat  <= 1'b1;
          line_cnt_r <= '0;
        end else if (word_s.lval && word_s.dval) begin
          line_cnt_r <= lval ? sat_inc(line_cnt_r) : CNT_W'(1);
        end
        if (fval_fall_s) begin
          frame_lines <= lines_next_s;
          frame_stat  <= 1'b1;
          frame_cnt_r <= '0;
        end else begin
          frame_cnt_r <= lines_next_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_clb_rx.sv
// Directed bench for clb_rx: a serial Camera Link Base source drives the lanes,
// a negedge monitor tallies output events, and the main sequence checks them.
module tb_clb_rx;

  localparam int CNT_W = 16;
  localparam logic [6:0] PAT = 7'b1100011;
  localparam logic [6:0] BAD = 7'b0000000;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       x_d;
  logic             x_clk;
  logic             pix_vld;
  logic [23:0]      pix_data;
  logic             lval, fval, dval, spare;
  logic             locked, lock_err;
  logic [CNT_W-1:0] line_len, frame_lines;
  logic             line_stat, frame_stat;

  always #5 clk = ~clk;

  clb_rx #(.LOCK_CNT(4), .UNLOCK_CNT(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .x_d(x_d), .x_clk(x_clk),
    .pix_vld(pix_vld), .pix_data(pix_data),
    .lval(lval), .fval(fval), .dval(dval), .spare(spare),
    .locked(locked), .lock_err(lock_err),
    .line_len(line_len), .line_stat(line_stat),
    .frame_lines(frame_lines), .frame_stat(frame_stat)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drv7_cyc = 0;

  int          vld_cnt = 0, vld_cyc = 0, vld_unlocked = 0;
  logic [23:0] last_data = 24'd0;
  logic [3:0]  last_flags = 4'd0;
  int          lerr_cnt = 0, ls_cnt = 0, ls_sum = 0, ls_last = 0;
  int          fs_cnt = 0, fs_last = 0, both_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pix_vld) begin
      vld_cnt    <= vld_cnt + 1;
      vld_cyc    <= cyc;
      last_data  <= pix_data;
      last_flags <= {spare, dval, fval, lval};
      if (!locked) vld_unlocked <= vld_unlocked + 1;
    end
    if (lock_err) lerr_cnt <= lerr_cnt + 1;
    if (line_stat) begin
      ls_cnt  <= ls_cnt + 1;
      ls_sum  <= ls_sum + int'(line_len);
      ls_last <= int'(line_len);
    end
    if (frame_stat) begin
      fs_cnt  <= fs_cnt + 1;
      fs_last <= int'(frame_lines);
    end
    if (line_stat && frame_stat) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] mk(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                     input logic l, input logic f, input logic d, input logic s);
    return {s, d, f, l, c, b, a};
  endfunction

  // Serial bit k of lane n is word bit n*7+k; XCLK sends the pattern MSB first.
  task automatic send_word(input logic [27:0] w, input logic [6:0] pat, input int k0);
    for (int k = k0; k < 7; k++) begin
      @(negedge clk);
      x_clk = pat[6-k];
      for (int n = 0; n < 4; n++) x_d[n] = w[n*7+k];
      if (k == 6) drv7_cyc = cyc;
    end
  endtask

  task automatic idle(input int n, input logic f);
    for (int i = 0; i < n; i++) send_word(mk(8'h00, 8'h00, 8'h00, 1'b0, f, 1'b0, 1'b0), PAT, 0);
  endtask

  task automatic send_line(input int npix);
    for (int i = 0; i < npix; i++) send_word(mk(8'(i), 8'(i >> 8), 8'h55, 1'b1, 1'b1, 1'b1, 1'b0), PAT, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; x_d = 4'd0; x_clk = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, "_flags"}, {23'd0, pix_vld, lval, fval, dval, spare, locked, lock_err, line_stat, frame_stat}, 32'd0);
    chk({tag, "_data"}, {8'd0, pix_data}, 32'd0);
    chk({tag, "_stats"}, {line_len, frame_lines}, 32'd0);
    rst = 1'b0;
  endtask

  int v0, e0, s0, sum0, f0, b0;
  logic [7:0] pa;

  initial begin
    rst = 1'b1; x_d = 4'd0; x_clk = 1'b0;
    repeat (2) @(negedge clk);
    do_reset("reset");

    // Lock acquisition on idle data
    idle(4, 1'b0);
    #1 chk("lock_early", {31'd0, locked}, 32'd0);
    idle(1, 1'b0);
    #1 chk("lock_t1", {31'd0, locked}, 32'd1);
    chk("no_vld_prelock", vld_cnt, 0);

    // Single word decode and latency
    send_word(mk(8'h5A, 8'hC3, 8'h81, 1'b1, 1'b1, 1'b1, 1'b0), PAT, 0);
    v0 = drv7_cyc;
    idle(1, 1'b0);
    #1 chk("t2_data", {8'd0, last_data}, 32'h0081C35A);
    chk("t2_flags", {28'd0, last_flags}, 32'h7);
    chk("t2_latency", vld_cyc - v0, 32'd2);
    chk("t2_vld_cnt", vld_cnt, 32'd2);

    // One corrupted XCLK period: lock held, one word missing
    v0 = vld_cnt;
    send_word(28'd0, BAD, 0);
    idle(2, 1'b0);
    #1 chk("t3_one_miss", vld_cnt - v0, 32'd2);
    chk("t3_still_locked", {31'd0, locked}, 32'd1);
    chk("t3_no_err", lerr_cnt, 32'd0);

    // Two corrupted periods: lock lost, flags forced low, relock
    e0 = lerr_cnt;
    send_word(mk(8'h12, 8'h34, 8'h56, 1'b1, 1'b1, 1'b1, 1'b0), PAT, 0);
    send_word(28'd0, BAD, 0);
    send_word(28'd0, BAD, 0);
    idle(1, 1'b0);
    #1 chk("t3_unlocked", {31'd0, locked}, 32'd0);
    chk("t3_lock_err", lerr_cnt - e0, 32'd1);
    chk("t3_flags_cleared", {29'd0, lval, fval, dval}, 32'd0);
    idle(3, 1'b0);
    #1 chk("t3_relock_early", {31'd0, locked}, 32'd0);
    idle(1, 1'b0);
    #1 chk("t3_relock", {31'd0, locked}, 32'd1);

    // Frame of 3 x 640 pixels
    s0 = ls_cnt; sum0 = ls_sum; f0 = fs_cnt;
    idle(2, 1'b0);
    for (int ln = 0; ln < 3; ln++) begin
      send_line(640);
      idle(10, 1'b1);
    end
    idle(2, 1'b0);
    #1 chk("t4_line_stats", ls_cnt - s0, 32'd3);
    chk("t4_line_sum", ls_sum - sum0, 32'd1920);
    chk("t4_line_len", {16'd0, line_len}, 32'd640);
    chk("t4_frame_stats", fs_cnt - f0, 32'd1);
    chk("t4_frame_lines", {16'd0, frame_lines}, 32'd3);

    // lval and fval fall in the same word
    b0 = both_cnt; f0 = fs_cnt;
    idle(1, 1'b1);
    send_line(5);
    idle(2, 1'b0);
    #1 chk("t4_both_pulse", both_cnt - b0, 32'd1);
    chk("t4_same_len", ls_last, 32'd5);
    chk("t4_same_frame", {16'd0, frame_lines}, 32'd1);

    // Every starting bit phase
    for (int p = 0; p < 7; p++) begin
      do_reset("t5_reset");
      send_word(28'd0, PAT, p);
      idle(5, 1'b0);
      #1 chk("t5_lock", {31'd0, locked}, 32'd1);
      pa = 8'(p * 17 + 3);
      send_word(mk(pa, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1), PAT, 0);
      idle(1, 1'b0);
      #1 chk("t5_data", {8'd0, last_data}, {8'd0, 8'h3C, 8'hA5, pa});
      chk("t5_flags", {28'd0, last_flags}, 32'hD);
    end

    // Reset mid-line, then a full line must report 640
    idle(1, 1'b1);
    send_line(100);
    do_reset("t6_reset");
    s0 = ls_cnt;
    idle(5, 1'b0);
    #1 chk("t6_relock", {31'd0, locked}, 32'd1);
    idle(1, 1'b1);
    send_line(640);
    idle(10, 1'b1);
    idle(2, 1'b0);
    #1 chk("t6_line_stats", ls_cnt - s0, 32'd1);
    chk("t6_line_len", {16'd0, line_len}, 32'd640);
    chk("t6_frame_lines", {16'd0, frame_lines}, 32'd1);
    chk("vld_only_locked", vld_unlocked, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clb_rx.md
Name: clb_rx

Overview:
- Camera Link Base receiver (deserializer/decoder).
- Accepts the 4 data lanes X0..X3 and the XCLK lane, sampled once per bit-clock cycle (clk = 7x pixel rate).
- Aligns to the 7-bit XCLK pattern, rebuilds the 28-bit parallel word, and emits pixel data plus LVAL/FVAL/DVAL.
- Measures line length and lines per frame.
- Sits between the LVDS input sampling (or the clb_lvds_if model in benches) and the video pipeline.
- Its word mapping is the exact inverse of the team's Camera Link Base transmit model.

Parameters:
- LOCK_CNT, 4: consecutive matching XCLK periods required to declare lock.
- UNLOCK_CNT, 2: consecutive mismatching periods while locked that drop lock.
- CNT_W, 16: width of the line-length and frame-line counters.

Ports:
- clk  in  1  bit clock. One clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- x_d  in  4  sampled data lanes; bit n = lane Xn.
- x_clk  in  1  sampled XCLK lane.
- pix_vld  out  1  one-cycle strobe: new word on outputs.
- pix_data  out  24  {port C, port B, port A}.
- lval  out  1  line valid of current word.
- fval  out  1  frame valid of current word.
- dval  out  1  data valid of current word.
- spare  out  1  spare bit.
- locked  out  1  alignment locked.
- lock_err  out  1  one-cycle pulse on loss of lock.
- line_len  out  CNT_W  pixels (lval&dval words) in last completed line.
- line_stat  out  1  pulse when line_len updates.
- frame_lines  out  CNT_W  lines in last completed frame.
- frame_stat  out  1  pulse when frame_lines updates.

Behaviour:
- Reset: all outputs 0, FSM in HUNT, all shift registers and counters cleared. Reset mid-operation has the same effect on the next edge.
- Shifting: each clk, x_clk and each x_d lane shift into 7-bit registers; the newest bit enters at LSB.
- Match: clock shift register == CLB_CLK_PAT (7'b1100011).
- Word assembly (at a match): serial bit k (k=0 first received) of lane n = lane_sh[n][6-k] and maps to word bit n*7+k.
  - Word fields: [7:0]=A, [15:8]=B, [23:16]=C, 24=LVAL, 25=FVAL, 26=DVAL, 27=spare.
- FSM HUNT:
  - Checks for a match every cycle.
  - On match: go to CHECK, phase=0, good=1.
- FSM CHECK:
  - phase counts 0..6; the check happens when phase wraps (exactly 7 clks after the previous check).
  - Match: good+1. When good==LOCK_CNT, go to LOCKED and assert locked.
  - Mismatch: go to HUNT.
  - No pix_vld in CHECK.
- FSM LOCKED:
  - Checks every 7 clks.
  - Match: bad=0; pix_vld and the word fields are registered on the next cycle (latency 1 clk after the 7th bit is sampled).
  - Mismatch: bad+1, no pix_vld, outputs hold.
  - When bad==UNLOCK_CNT: go to HUNT, locked=0, lock_err=1 for 1 cycle, lval/fval/dval forced 0, counters cleared.
- Line statistics (evaluated on pix_vld words only):
  - Line counter increments when lval&dval, saturating at 2^CNT_W-1.
  - On lval 1->0 (previous word vs current word): line_len<=counter, line_stat pulse, counter<=0.
  - If a word has lval 0->1 and dval, the counter restarts at 1.
- Frame statistics:
  - Line-in-frame counter increments on each lval falling edge while fval=1, saturating.
  - On fval 1->0: frame_lines<=counter, frame_stat pulse, counter<=0.
  - If lval and fval fall in the same word, the line is counted first, then frame_lines latches including it; line_stat and frame_stat pulse in the same cycle.

Decomposition:
- Additions to clb_pkg:
  - CLB_LANES=4, CLB_SER=7, CLB_CLK_PAT=7'b1100011.
  - Field index constants (CLB_LVAL_IDX=24, CLB_FVAL_IDX=25, CLB_DVAL_IDX=26, CLB_SPARE_IDX=27).
  - typedef clb_word_t: packed struct {spare, dval, fval, lval, c, b, a}.
  - These are shared with the transmit driver so both ends use one mapping.
- One sub-module, clb_rx_align: the shift registers, HUNT/CHECK/LOCKED FSM and phase counter. It outputs word_vld, clb_word_t, locked and lock_err.
- clb_rx top holds output registers and the statistics counters.

Test Plan:
1. Continuous XCLK 1100011 after reset, idle data -> locked rises after LOCK_CNT=4 periods (first match + 3 checks); no pix_vld before locked.
2. Locked, send word A=8'h5A, B=8'hC3, C=8'h81, LVAL=1, FVAL=1, DVAL=1, spare=0 -> pix_vld pulse with pix_data=24'h81C35A, lval=fval=dval=1, spare=0, one clk after the 7th bit.
3. Locked, corrupt XCLK for 1 period, then 2 consecutive periods -> first case: no lock loss, one missing pix_vld; second case: lock_err pulse, locked=0, return to HUNT, then relock after 4 good periods.
4. Frame of 3 lines x 640 lval&dval pixels with 10 blanking words between -> 3 line_stat pulses with line_len=640, then frame_stat with frame_lines=3.
5. Start XCLK at a random bit phase 0..6 -> lock and correct word decode for every phase.
6. Assert rst mid-line while locked -> next cycle all outputs 0 and FSM in HUNT; the following frame's line_len reports a full 640, not a partial count.
